// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset release sequencer: state encoding and
// width-derivation helpers used by the top and the timer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_DELAY    = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_DONE     = 2'd2
  } seq_state_t;

  // Ceiling log2 for elaboration-time width math.
  function automatic int clog2_f(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << w) < 64'(value)) begin
        w = w + 1;
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

  // Stage index width; never narrower than one bit.
  function automatic int idx_w_f(input int num_outs);
    return (num_outs <= 1) ? 1 : clog2_f(num_outs);
  endfunction

  // Counter width covering both the settle delay and the ack timeout.
  function automatic int cnt_w_f(input int dly_cycles, input int tmo_cycles);
    int m;
    int w;
    m = (dly_cycles > tmo_cycles) ? dly_cycles : tmo_cycles;
    w = clog2_f(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// Clearable up-counter with a terminal-count compare. One instance serves
// both the settle-delay and the ack-timeout phases of the sequencer.
module rst_seq_timer
  import rst_seq_pkg::*;
#(
  parameter int CNT_W = 10
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] tc_val,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_r;

  // Count up while enabled; clear has priority so every phase starts at zero.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (en) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tc = (cnt_r == tc_val);

endmodule

// File: rtl/rst_seq.sv
// Reset release sequencer: releases NUM_OUTS downstream resets one at a time
// in index order, each after a settle delay, then waits for the stage's ack
// with a timeout. A software request re-asserts everything and restarts.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter  int NUM_OUTS   = 4,
  parameter  int DLY_CYCLES = 16,
  parameter  int TMO_CYCLES = 1024,
  localparam int IDX_W      = idx_w_f(NUM_OUTS),
  localparam int CNT_W      = cnt_w_f(DLY_CYCLES, TMO_CYCLES)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                SW_RST_REQ,
  input  logic [NUM_OUTS-1:0] STAGE_ACK,
  output logic [NUM_OUTS-1:0] RST_OUT_N,
  output logic                SEQ_DONE,
  output logic                TMO_ERR,
  output logic [IDX_W-1:0]    TMO_STAGE
);

  localparam logic [CNT_W-1:0] DLY_TC   = CNT_W'(DLY_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_TC   = CNT_W'(TMO_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OUTS - 1);
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

  seq_state_t          state_r;
  seq_state_t          state_s;
  logic [IDX_W-1:0]    idx_r;
  logic [IDX_W-1:0]    idx_s;
  logic [NUM_OUTS-1:0] rst_out_r;
  logic [NUM_OUTS-1:0] rst_out_s;
  logic                seq_done_r;
  logic                seq_done_s;
  logic                tmo_err_r;
  logic                tmo_err_s;
  logic [IDX_W-1:0]    tmo_stage_r;
  logic [IDX_W-1:0]    tmo_stage_s;

  logic                tmr_clr_s;
  logic                tmr_en_s;
  logic                tmr_tc_s;
  logic [CNT_W-1:0]    tmr_tc_val_s;
  logic                ack_cur_s;

  rst_seq_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .CLK    (CLK),
    .RST    (RST),
    .clr    (tmr_clr_s),
    .en     (tmr_en_s),
    .tc_val (tmr_tc_val_s),
    .tc     (tmr_tc_s)
  );

  // Only the ack of the stage currently being waited on matters.
  assign ack_cur_s = STAGE_ACK[idx_r];

  // Terminal count follows the phase: timeout while waiting, settle otherwise.
  always_comb begin
    tmr_tc_val_s = DLY_TC;
    if (state_r == ST_WAIT_ACK) begin
      tmr_tc_val_s = TMO_TC;
    end else begin
      tmr_tc_val_s = DLY_TC;
    end
  end

  // Next-state and next-output logic; software request overrides everything.
  always_comb begin
    state_s     = state_r;
    idx_s       = idx_r;
    rst_out_s   = rst_out_r;
    seq_done_s  = seq_done_r;
    tmo_err_s   = tmo_err_r;
    tmo_stage_s = tmo_stage_r;
    tmr_clr_s   = 1'b0;
    tmr_en_s    = 1'b0;

    if (SW_RST_REQ) begin
      state_s    = ST_DELAY;
      idx_s      = {IDX_W{1'b0}};
      rst_out_s  = {NUM_OUTS{1'b0}};
      seq_done_s = 1'b0;
      tmr_clr_s  = 1'b1;
    end else begin
      case (state_r)
        ST_DELAY: begin
          if (tmr_tc_s) begin
            rst_out_s[idx_r] = 1'b1;
            tmr_clr_s        = 1'b1;
            state_s          = ST_WAIT_ACK;
          end else begin
            tmr_en_s = 1'b1;
          end
        end
        ST_WAIT_ACK: begin
          if (ack_cur_s || tmr_tc_s) begin
            // A timeout only counts when the ack did not arrive on this edge.
            if (!ack_cur_s && !tmo_err_r) begin
              tmo_err_s   = 1'b1;
              tmo_stage_s = idx_r;
            end else begin
              tmo_err_s   = tmo_err_r;
            end
            tmr_clr_s = 1'b1;
            if (idx_r == LAST_IDX) begin
              state_s    = ST_DONE;
              seq_done_s = 1'b1;
            end else begin
              idx_s   = idx_r + ONE_IDX;
              state_s = ST_DELAY;
            end
          end else begin
            tmr_en_s = 1'b1;
          end
        end
        ST_DONE: begin
          state_s = ST_DONE;
        end
        default: begin
          state_s    = ST_DELAY;
          idx_s      = {IDX_W{1'b0}};
          rst_out_s  = {NUM_OUTS{1'b0}};
          seq_done_s = 1'b0;
          tmr_clr_s  = 1'b1;
        end
      endcase
    end
  end

  // State and registered outputs; RST clears everything including the error.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r     <= ST_DELAY;
      idx_r       <= {IDX_W{1'b0}};
      rst_out_r   <= {NUM_OUTS{1'b0}};
      seq_done_r  <= 1'b0;
      tmo_err_r   <= 1'b0;
      tmo_stage_r <= {IDX_W{1'b0}};
    end else begin
      state_r     <= state_s;
      idx_r       <= idx_s;
      rst_out_r   <= rst_out_s;
      seq_done_r  <= seq_done_s;
      tmo_err_r   <= tmo_err_s;
      tmo_stage_r <= tmo_stage_s;
    end
  end

  assign RST_OUT_N = rst_out_r;
  assign SEQ_DONE  = seq_done_r;
  assign TMO_ERR   = tmo_err_r;
  assign TMO_STAGE = tmo_stage_r;

endmodule

// File: tb/tb_rst_seq.sv
// Self-checking bench for rst_seq: directed scenarios with arithmetic
// expectations plus a randomized run against a behavioural model.
module tb_rst_seq;

  localparam int N = 4;
  localparam int D = 16;
  localparam int T = 1024;

  logic         clk = 1'b0;
  logic         rst;
  logic         sw_rst_req;
  logic [N-1:0] stage_ack;
  logic [N-1:0] rst_out_n;
  logic         seq_done;
  logic         tmo_err;
  logic [1:0]   tmo_stage;

  int n_cmp = 0;
  int n_bad = 0;

  // behavioural model state
  logic [N-1:0] m_out;
  logic         m_done;
  logic         m_err;
  int           m_tstage;
  int           m_stage;
  int           m_elapsed;
  bit           m_waiting;
  bit           m_finished;

  always #5 clk = ~clk;

  rst_seq #(.NUM_OUTS(N), .DLY_CYCLES(D), .TMO_CYCLES(T)) dut (
    .CLK        (clk),
    .RST        (rst),
    .SW_RST_REQ (sw_rst_req),
    .STAGE_ACK  (stage_ack),
    .RST_OUT_N  (rst_out_n),
    .SEQ_DONE   (seq_done),
    .TMO_ERR    (tmo_err),
    .TMO_STAGE  (tmo_stage)
  );

  task automatic model_reset();
    m_out = '0; m_done = 1'b0; m_err = 1'b0; m_tstage = 0;
    m_stage = 0; m_elapsed = 0; m_waiting = 1'b0; m_finished = 1'b0;
  endtask

  // One clock edge of the sequencer described in terms of stages and elapsed time.
  task automatic model_edge(input logic s, input logic [N-1:0] a);
    bit acked, timed;
    if (s) begin
      m_out = '0; m_done = 1'b0; m_stage = 0; m_elapsed = 0;
      m_waiting = 1'b0; m_finished = 1'b0;
    end else if (m_finished) begin
      m_finished = 1'b1;
    end else if (!m_waiting) begin
      if (m_elapsed + 1 == D) begin
        m_out[m_stage] = 1'b1; m_waiting = 1'b1; m_elapsed = 0;
      end else begin
        m_elapsed++;
      end
    end else begin
      acked = a[m_stage];
      timed = (m_elapsed + 1 == T);
      if (acked || timed) begin
        if (!acked && !m_err) begin
          m_err = 1'b1; m_tstage = m_stage;
        end
        m_elapsed = 0;
        if (m_stage == N - 1) begin
          m_finished = 1'b1; m_done = 1'b1;
        end else begin
          m_stage++; m_waiting = 1'b0;
        end
      end else begin
        m_elapsed++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(sw_rst_req, stage_ack);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    sw_rst_req = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    #12;
    rst = 1'b0;
    #1;
    n_cmp++; if (rst_out_n !== 4'b0000) begin n_bad++; $display("FAIL reset_out got %b want 0000", rst_out_n); end
    n_cmp++; if (seq_done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", seq_done); end
    n_cmp++; if (tmo_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", tmo_err); end
    n_cmp++; if (tmo_stage !== 2'd0) begin n_bad++; $display("FAIL reset_stage got %0d want 0", tmo_stage); end
    model_reset();
  endtask

  task automatic test_basic();
    int rise[N];
    int done_at;
    apply_reset();
    stage_ack = '1;
    for (int b = 0; b < N; b++) rise[b] = -1;
    done_at = -1;
    for (int t = 1; t <= 90; t++) begin
      tick();
      for (int b = 0; b < N; b++) if (rise[b] < 0 && rst_out_n[b] === 1'b1) rise[b] = t;
      if (done_at < 0 && seq_done === 1'b1) done_at = t;
    end
    for (int b = 0; b < N; b++) begin
      n_cmp++;
      if (rise[b] != D + b * (D + 1)) begin
        n_bad++; $display("FAIL basic_rise%0d got edge %0d want %0d", b, rise[b], D + b * (D + 1));
      end
    end
    n_cmp++; if (done_at != D * N + N) begin n_bad++; $display("FAIL basic_done got edge %0d want %0d", done_at, D * N + N); end
    n_cmp++; if (tmo_err !== 1'b0) begin n_bad++; $display("FAIL basic_err got %b want 0", tmo_err); end
  endtask

  task automatic test_timeout();
    int err_at, rise3, done_at;
    apply_reset();
    stage_ack = 4'b1011;
    err_at = -1; rise3 = -1; done_at = -1;
    for (int t = 1; t <= 1200; t++) begin
      tick();
      if (err_at < 0 && tmo_err === 1'b1) err_at = t;
      if (rise3 < 0 && rst_out_n[3] === 1'b1) rise3 = t;
      if (done_at < 0 && seq_done === 1'b1) done_at = t;
    end
    n_cmp++; if (err_at != 2 * (D + 1) + D + T) begin n_bad++; $display("FAIL tmo_err_edge got %0d want %0d", err_at, 2 * (D + 1) + D + T); end
    n_cmp++; if (tmo_stage !== 2'd2) begin n_bad++; $display("FAIL tmo_stage got %0d want 2", tmo_stage); end
    n_cmp++; if (rise3 != 2 * (D + 1) + D + T + D) begin n_bad++; $display("FAIL tmo_rise3 got %0d want %0d", rise3, 2 * (D + 1) + D + T + D); end
    n_cmp++; if (done_at != rise3 + 1) begin n_bad++; $display("FAIL tmo_done got %0d want %0d", done_at, rise3 + 1); end
    // software restart must keep the recorded error
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    n_cmp++; if (rst_out_n !== 4'b0000) begin n_bad++; $display("FAIL tmo_sw_out got %b want 0000", rst_out_n); end
    n_cmp++; if (seq_done !== 1'b0) begin n_bad++; $display("FAIL tmo_sw_done got %b want 0", seq_done); end
    n_cmp++; if (tmo_err !== 1'b1 || tmo_stage !== 2'd2) begin n_bad++; $display("FAIL tmo_sw_keep got err=%b stage=%0d want err=1 stage=2", tmo_err, tmo_stage); end
  endtask

  task automatic test_rst_mid();
    int rise0, done_at;
    stage_ack = '1;
    for (int t = 1; t <= 40; t++) tick();
    n_cmp++; if (rst_out_n !== 4'b0011) begin n_bad++; $display("FAIL mid_pre got %b want 0011", rst_out_n); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (rst_out_n !== 4'b0000) begin n_bad++; $display("FAIL mid_out got %b want 0000", rst_out_n); end
    n_cmp++; if (tmo_err !== 1'b0 || tmo_stage !== 2'd0) begin n_bad++; $display("FAIL mid_err got err=%b stage=%0d want 0/0", tmo_err, tmo_stage); end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    rise0 = -1; done_at = -1;
    for (int t = 1; t <= 80; t++) begin
      tick();
      if (rise0 < 0 && rst_out_n[0] === 1'b1) rise0 = t;
      if (done_at < 0 && seq_done === 1'b1) done_at = t;
    end
    n_cmp++; if (rise0 != D) begin n_bad++; $display("FAIL mid_rise0 got %0d want %0d", rise0, D); end
    n_cmp++; if (done_at != D * N + N) begin n_bad++; $display("FAIL mid_done got %0d want %0d", done_at, D * N + N); end
  endtask

  task automatic test_sw_rst();
    int rise0;
    apply_reset();
    stage_ack = 4'b1101;
    for (int t = 1; t <= 40; t++) tick();
    n_cmp++; if (rst_out_n !== 4'b0011) begin n_bad++; $display("FAIL sw_pre got %b want 0011", rst_out_n); end
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    n_cmp++; if (rst_out_n !== 4'b0000 || seq_done !== 1'b0) begin n_bad++; $display("FAIL sw_pulse got out=%b done=%b want 0000/0", rst_out_n, seq_done); end
    n_cmp++; if (tmo_err !== 1'b0) begin n_bad++; $display("FAIL sw_err got %b want 0", tmo_err); end
    stage_ack = '1;
    rise0 = -1;
    for (int t = 1; t <= 30; t++) begin
      tick();
      if (rise0 < 0 && rst_out_n[0] === 1'b1) rise0 = t;
    end
    n_cmp++; if (rise0 != D) begin n_bad++; $display("FAIL sw_rise0 got %0d want %0d", rise0, D); end
    sw_rst_req = 1'b1;
    for (int t = 1; t <= 30; t++) tick();
    n_cmp++; if (rst_out_n !== 4'b0000 || seq_done !== 1'b0) begin n_bad++; $display("FAIL sw_hold got out=%b done=%b want 0000/0", rst_out_n, seq_done); end
    sw_rst_req = 1'b0;
    rise0 = -1;
    for (int t = 1; t <= 30; t++) begin
      tick();
      if (rise0 < 0 && rst_out_n[0] === 1'b1) rise0 = t;
    end
    n_cmp++; if (rise0 != D) begin n_bad++; $display("FAIL sw_hold_rise0 got %0d want %0d", rise0, D); end
  endtask

  task automatic test_ack_on_tmo();
    apply_reset();
    stage_ack = 4'b0000;
    for (int t = 1; t <= D + T - 1; t++) tick();
    stage_ack = 4'b0001;
    tick();
    n_cmp++; if (tmo_err !== 1'b0) begin n_bad++; $display("FAIL ackwin_err got %b want 0", tmo_err); end
    stage_ack = 4'b1111;
    for (int t = 1; t <= D - 1; t++) tick();
    n_cmp++; if (rst_out_n !== 4'b0001) begin n_bad++; $display("FAIL ackwin_pre1 got %b want 0001", rst_out_n); end
    tick();
    n_cmp++; if (rst_out_n !== 4'b0011) begin n_bad++; $display("FAIL ackwin_rise1 got %b want 0011", rst_out_n); end
  endtask

  task automatic test_early_ack();
    int rise3, done_at;
    bit early_done;
    apply_reset();
    stage_ack = 4'b1000;
    rise3 = -1; done_at = -1; early_done = 1'b0;
    for (int t = 1; t <= 100; t++) begin
      tick();
      if (t == 20) stage_ack = 4'b1001;
      if (t == 40) stage_ack = 4'b1011;
      if (t == 60) stage_ack = 4'b1111;
      if (rise3 < 0 && rst_out_n[3] === 1'b1) rise3 = t;
      if (done_at < 0 && seq_done === 1'b1) done_at = t;
      if (t < 61 && seq_done !== 1'b0) early_done = 1'b1;
    end
    n_cmp++; if (rise3 != 61 + D) begin n_bad++; $display("FAIL early_rise3 got %0d want %0d", rise3, 61 + D); end
    n_cmp++; if (done_at != 62 + D) begin n_bad++; $display("FAIL early_done got %0d want %0d", done_at, 62 + D); end
    n_cmp++; if (early_done) begin n_bad++; $display("FAIL early_done_flag got 1 want 0"); end
    n_cmp++; if (tmo_err !== 1'b0) begin n_bad++; $display("FAIL early_err got %b want 0", tmo_err); end
  endtask

  task automatic test_random();
    int mode;
    apply_reset();
    for (int c = 0; c < 6000; c++) begin
      mode = (c / 1500) % 2;
      for (int b = 0; b < N; b++) begin
        stage_ack[b] = (mode == 0) ? ($urandom_range(0, 31) == 0) : 1'b0;
      end
      sw_rst_req = ($urandom_range(0, 799) == 0);
      tick();
      n_cmp++; if (rst_out_n !== m_out) begin n_bad++; $display("FAIL rnd_out cyc %0d got %b want %b", c, rst_out_n, m_out); end
      n_cmp++; if (seq_done !== m_done) begin n_bad++; $display("FAIL rnd_done cyc %0d got %b want %b", c, seq_done, m_done); end
      n_cmp++; if (tmo_err !== m_err) begin n_bad++; $display("FAIL rnd_err cyc %0d got %b want %b", c, tmo_err, m_err); end
      n_cmp++; if (tmo_stage !== 2'(m_tstage)) begin n_bad++; $display("FAIL rnd_stage cyc %0d got %0d want %0d", c, tmo_stage, m_tstage); end
    end
    sw_rst_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    sw_rst_req = 1'b0;
    stage_ack = '0;
    model_reset();
    test_reset();
    test_basic();
    test_timeout();
    test_rst_mid();
    test_sw_rst();
    test_ack_on_tmo();
    test_early_ack();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rst_seq.md
Name: rst_seq

Overview:
- Reset release sequencer; sits directly downstream of the reset synchronizer in each clock domain.
- Takes the synchronized, active-low domain reset.
- Deasserts NUM_OUTS per-block resets one at a time, in index order. Each release is preceded by a programmable settle delay and followed by a wait for a per-stage ready/ack, with a timeout.
- Also supports a software-requested full re-sequence.

Parameters:
- NUM_OUTS, 4: number of sequenced reset outputs; legal range 1..16.
- DLY_CYCLES, 16: settle cycles before each stage release; legal range >= 1.
- TMO_CYCLES, 1024: maximum WAIT_ACK cycles per stage before a timeout; legal range >= 1.

Ports:
- CLK  in  1  domain clock.
- RST  in  1  reset, asynchronous, active-low; driven by the synchronized reset of this domain.
- SW_RST_REQ  in  1  synchronous request to re-assert all outputs and restart the sequence; level-sampled each edge.
- STAGE_ACK  in  NUM_OUTS  bit k = stage k is out of reset and ready; must already be synchronous to CLK.
- RST_OUT_N  out  NUM_OUTS  active-low resets to the downstream blocks; registered.
- SEQ_DONE  out  1  high when all stages are released and acknowledged or timed out.
- TMO_ERR  out  1  sticky; set on the first stage timeout.
- TMO_STAGE  out  IDX_W  index of the first stage that timed out.

Behaviour:
Reset (RST low, asynchronous):
- RST_OUT_N = all 0, SEQ_DONE = 0, TMO_ERR = 0, TMO_STAGE = 0.
- State = DELAY, stage index k = 0, counter cnt = 0.
- Takes effect immediately, with no clock edge needed, from any state.

States: DELAY, WAIT_ACK, DONE.

DELAY:
- Each edge: if cnt == DLY_CYCLES-1, then RST_OUT_N[k] <= 1, cnt <= 0, go to WAIT_ACK.
- Otherwise cnt++.
- Result: RST_OUT_N[0] rises on the DLY_CYCLES-th edge after RST deasserts.

WAIT_ACK:
- STAGE_ACK[k] sampled 1 counts as acknowledged.
  - If k == NUM_OUTS-1: go to DONE, SEQ_DONE <= 1.
  - Otherwise: k++, cnt <= 0, go to DELAY.
- If there is no ack and cnt == TMO_CYCLES-1:
  - Timeout. If TMO_ERR == 0, set TMO_ERR <= 1 and TMO_STAGE <= k.
  - Then proceed exactly as for an ack; the sequence never deadlocks.
- Otherwise cnt++.
- Ack and timeout on the same edge: the ack wins and no error is recorded.

DONE:
- Outputs hold; all RST_OUT_N = 1, SEQ_DONE = 1.
- STAGE_ACK changes are ignored.

Ack handling:
- Only STAGE_ACK[k] is examined, and only while in WAIT_ACK.
- Acks for unreleased or already-acknowledged stages are ignored.
- A stage that drops its ack after acknowledgment has no effect.

Output hold:
- A released RST_OUT_N bit stays 1 until RST or SW_RST_REQ.

SW_RST_REQ sampled 1, in any state:
- Next edge: RST_OUT_N <= all 0, SEQ_DONE <= 0, k <= 0, cnt <= 0, state <= DELAY.
- Priority: it takes precedence over ack, timeout and release on the same edge.
- Held high: the block stays in DELAY with cnt = 0 and all outputs low.
- TMO_ERR and TMO_STAGE are NOT cleared; only RST clears them.

Ordering and widths:
- Outputs are released strictly in index order, and never two on the same edge.
- IDX_W = max(1, clog2(NUM_OUTS)).
- CNT_W = clog2(max(DLY_CYCLES, TMO_CYCLES)).
- The counter never wraps; it is always cleared on each state change.

Decomposition:
- Shared package rst_seq_pkg:
  - state enum {DELAY, WAIT_ACK, DONE};
  - functions/constants deriving IDX_W and CNT_W.
- One natural sub-module: rst_seq_timer.
  - Clearable up-counter with a terminal-count compare input.
  - Shared by the delay and timeout phases.

Test Plan:
1. NUM_OUTS=4, DLY=16, STAGE_ACK tied all 1, RST released before edge 1 -> RST_OUT_N[0..3] rise after edges 16/33/50/67; SEQ_DONE rises after edge 68; TMO_ERR=0.
2. TMO_CYCLES=1024, STAGE_ACK[2] held 0, others 1 -> after 1024 cycles in WAIT_ACK for stage 2: TMO_ERR=1, TMO_STAGE=2; stage 3 is released 16 edges later; SEQ_DONE=1.
3. SW_RST_REQ pulsed for 1 cycle while in WAIT_ACK for stage 1 -> next edge RST_OUT_N=4'b0000, SEQ_DONE=0; the sequence restarts with stage 0 released 16 edges later; TMO_ERR is unchanged.
4. RST driven low between clock edges during DELAY for stage 2 -> RST_OUT_N=0 and TMO_ERR=0 with no clock edge; after release, the full sequence repeats from stage 0.
5. Force STAGE_ACK[k] to rise on exactly the timeout edge -> TMO_ERR stays 0; the next stage proceeds normally.
6. STAGE_ACK=4'b1000 from reset, then stages 0..2 acked in turn -> RST_OUT_N[3] is not released before 16 edges after stage 2's ack; no early DONE.
